// File: rtl/dir_ctrl_debounce_pkg.sv
// dir_ctrl_debounce_pkg: shared state encodings and mode constants for the direction-button conditioner.
package dir_ctrl_debounce_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HELD    = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;
    localparam logic MODE_LEVEL  = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;
endpackage

// File: rtl/dir_ctrl_debounce_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-high reset, shared by all button inputs.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/dir_ctrl_debounce.sv
// dir_ctrl_debounce: debounces a raw direction button and drives the counter's up/down control.
// Optional PRESS_COUNT_EN adds a saturating 8-bit press counter output.
module dir_ctrl_debounce
    import dir_ctrl_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             mode,
    output logic             control,
    output logic             press_pulse
`ifdef PRESS_COUNT_EN
    ,
    output logic [7:0]       press_count
`endif
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    logic btn_s;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic deb_q, deb_d, pulse_q, pulse_d, control_q, control_d;
    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_raw),
        .q_o (btn_s)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: if (btn_s) begin
                state_d = ST_WAIT_HI;
                cnt_d   = CNT_W'(1);
            end
            ST_WAIT_HI: if (!btn_s) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_HELD;
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
            ST_HELD: if (!btn_s) begin
                state_d = ST_WAIT_LO;
                cnt_d   = CNT_W'(1);
            end
            ST_WAIT_LO: if (btn_s) begin
                state_d = ST_HELD;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        deb_d     = (state_d == ST_HELD) || (state_d == ST_WAIT_LO);
        // Use next-state values so control moves in the same cycle as deb/press_pulse
        control_d = (mode == MODE_LEVEL) ? deb_d : (pulse_d ? ~control_q : control_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            pulse_q   <= 1'b0;
            control_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            pulse_q   <= pulse_d;
            control_q <= control_d;
        end
    end
    assign control     = control_q;
    assign press_pulse = pulse_q;
`ifdef PRESS_COUNT_EN
    logic [7:0] press_count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) press_count_q <= '0;
        else if (pulse_d && press_count_q != 8'hFF) press_count_q <= press_count_q + 8'd1;
    end
    assign press_count = press_count_q;
`endif
endmodule

// File: tb/tb_dir_ctrl_debounce.sv
// tb_dir_ctrl_debounce: directed self-checking bench for dir_ctrl_debounce (DEB_CYCLES=4).
module tb_dir_ctrl_debounce;
    logic clk, rst, btn_raw, mode, control, press_pulse;
    int errors = 0;
    int checks = 0;
    int pulses = 0;
`ifdef PRESS_COUNT_EN
    logic [7:0] press_count;
`endif
    dir_ctrl_debounce #(.DEB_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .mode        (mode),
        .control     (control),
        .press_pulse (press_pulse)
`ifdef PRESS_COUNT_EN
        ,
        .press_count (press_count)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        if (press_pulse === 1'b1) pulses++;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        btn_raw = 1'b0;
        step();
        step();
        rst = 1'b0;
        pulses = 0;
    endtask
    initial begin
        rst = 1'b1;
        btn_raw = 1'b0;
        mode = 1'b0;
        #12 rst = 1'b0;
        // 1: reset state stable
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("t1_ctrl[%0d]", n), control, 1'b0);
            chk($sformatf("t1_pulse[%0d]", n), press_pulse, 1'b0);
        end
        // 2: toggle mode, clean press
        do_reset();
        mode = 1'b1;
        btn_raw = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("t2_pulse[%0d]", n), press_pulse, n == 6);
            chk($sformatf("t2_ctrl[%0d]", n), control, n >= 6);
        end
        // 3: bounce rejected
        do_reset();
        mode = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            btn_raw = (n <= 2) || (n == 5) || (n == 6);
            step();
            chk($sformatf("t3_pulse[%0d]", n), press_pulse, 1'b0);
            chk($sformatf("t3_ctrl[%0d]", n), control, 1'b0);
        end
        // 4: level mode, press then release
        do_reset();
        mode = 1'b0;
        btn_raw = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            chk($sformatf("t4_ctrl_hi[%0d]", n), control, n >= 6);
            chk($sformatf("t4_pulse_hi[%0d]", n), press_pulse, n == 6);
        end
        btn_raw = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            chk($sformatf("t4_ctrl_lo[%0d]", n), control, n < 6);
            chk($sformatf("t4_pulse_lo[%0d]", n), press_pulse, 1'b0);
        end
        // 5: two presses in toggle mode
        do_reset();
        mode = 1'b1;
        btn_raw = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("t5_p1_pulse[%0d]", n), press_pulse, n == 6);
            chk($sformatf("t5_p1_ctrl[%0d]", n), control, n >= 6);
        end
        btn_raw = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("t5_gap_pulse[%0d]", n), press_pulse, 1'b0);
            chk($sformatf("t5_gap_ctrl[%0d]", n), control, 1'b1);
        end
        btn_raw = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("t5_p2_pulse[%0d]", n), press_pulse, n == 6);
            chk($sformatf("t5_p2_ctrl[%0d]", n), control, n < 6);
        end
        checks++;
        assert (pulses == 2) else begin
            errors++;
            $error("FAIL t5_pulse_total: observed=%0d expected=2", pulses);
        end
`ifdef PRESS_COUNT_EN
        checks++;
        assert (press_count === 8'd2) else begin
            errors++;
            $error("FAIL t5_press_count: observed=%0d expected=2", press_count);
        end
`endif
        // 6: reset mid-WAIT_HI, then fresh press
        do_reset();
        mode = 1'b1;
        btn_raw = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk($sformatf("t6_pre_pulse[%0d]", n), press_pulse, 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", control, 1'b0);
        chk("t6_rst_pulse", press_pulse, 1'b0);
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("t6_inrst_pulse[%0d]", n), press_pulse, 1'b0);
            chk($sformatf("t6_inrst_ctrl[%0d]", n), control, 1'b0);
        end
        rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("t6_post_pulse[%0d]", n), press_pulse, n == 6);
            chk($sformatf("t6_post_ctrl[%0d]", n), control, n >= 6);
        end
`ifdef PRESS_COUNT_EN
        checks++;
        assert (press_count === 8'd1) else begin
            errors++;
            $error("FAIL t6_press_count: observed=%0d expected=1", press_count);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
